// File: rtl/log_afpm_pkg.sv
// Shared types, flag bit positions and width helpers for the serial
// logarithmic approximate FP multiplier.
package log_afpm_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        SEND    = 2'd2
    } state_e;

    localparam int F_NAN  = 3;
    localparam int F_OVF  = 2;
    localparam int F_UNF  = 1;
    localparam int F_ZERO = 0;

    function automatic int word_w_f(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    function automatic int beats_f(input int word_w, input int bus_w);
        return (word_w + bus_w - 1) / bus_w;
    endfunction

    function automatic int bias_f(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/log_afpm_serial_if.sv
// Beat-serial operand/result bus between the I/O shim, the multiplier and the sink.
interface log_afpm_serial_if #(
    parameter int BUS_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [BUS_W-1:0] a_in;
    logic [BUS_W-1:0] b_in;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [BUS_W-1:0] out_data;
    logic             out_last;
    logic [3:0]       flags;

    modport slave (
        input  in_valid, a_in, b_in, mode, out_ready,
        output in_ready, out_valid, out_data, out_last, flags
    );

    modport master (
        output in_valid, a_in, b_in, mode, out_ready,
        input  in_ready, out_valid, out_data, out_last, flags
    );
endinterface

// File: rtl/log_afpm_core.sv
// Combinational Mitchell log-domain multiplier: exponent/mantissa fields are
// added as one fixed-point log value, then special cases are resolved.
module log_afpm_core
    import log_afpm_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int COMP  = 58
) (
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 mode,
    output logic [EXP_W+MAN_W:0] res,
    output logic [3:0]           flags
);
    localparam int EM = EXP_W + MAN_W;
    localparam int SW = EM + 2;
    localparam int BIAS = bias_f(EXP_W);
    localparam logic signed [SW-1:0] BIAS_SH = SW'(BIAS) << MAN_W;
    localparam logic signed [SW-1:0] OVF_TH  = SW'((1 << EXP_W) - 1) << MAN_W;
    localparam logic signed [SW-1:0] UNF_TH  = SW'(1) << MAN_W;

    logic signed [SW-1:0] s;
    logic sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign s = $signed({2'b00, a[EM-1:0]}) + $signed({2'b00, b[EM-1:0]})
             + (mode ? SW'(COMP) : SW'(0)) - BIAS_SH;

    assign sign   = a[EM] ^ b[EM];
    assign a_zero = (a[EM-1:MAN_W] == '0);
    assign b_zero = (b[EM-1:MAN_W] == '0);
    assign a_inf  = (a[EM-1:MAN_W] == '1) && (a[MAN_W-1:0] == '0);
    assign b_inf  = (b[EM-1:MAN_W] == '1) && (b[MAN_W-1:0] == '0);
    assign a_nan  = (a[EM-1:MAN_W] == '1) && (a[MAN_W-1:0] != '0);
    assign b_nan  = (b[EM-1:MAN_W] == '1) && (b[MAN_W-1:0] != '0);

    always_comb begin
        res   = '0;
        flags = '0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            res          = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            flags[F_NAN] = 1'b1;
        end else if (a_zero || b_zero) begin
            // subnormals land here too: flushed to zero
            res           = {sign, {EM{1'b0}}};
            flags[F_ZERO] = 1'b1;
        end else if (a_inf || b_inf) begin
            res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (s >= OVF_TH) begin
            res          = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags[F_OVF] = 1'b1;
        end else if (s < UNF_TH) begin
            res           = {sign, {EM{1'b0}}};
            flags[F_UNF]  = 1'b1;
            flags[F_ZERO] = 1'b1;
        end else begin
            res = {sign, s[EM-1:0]};
        end
    end
endmodule

// File: rtl/log_afpm_serial.sv
// Serial wrapper: gathers operand beats, computes in one cycle, streams the
// result back LSB beat first. Load and send phases never overlap.
module log_afpm_serial
    import log_afpm_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int BUS_W = 8,
    parameter int COMP  = 58
) (
    input logic              clk,
    input logic              rst,
    log_afpm_serial_if.slave bus
);
    localparam int WORD_W = word_w_f(EXP_W, MAN_W);
    localparam int BEATS  = beats_f(WORD_W, BUS_W);
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_in_q, cnt_in_d, cnt_out_q, cnt_out_d;
    logic [WORD_W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d, core_res;
    logic               mode_q, mode_d;
    logic [3:0]         flags_q, flags_d, core_flags;
    logic               in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic [BUS_W-1:0]   out_data_q, out_data_d;

    function automatic logic [BUS_W-1:0] beat_of(input logic [WORD_W-1:0] w, input int idx);
        beat_of = '0;
        for (int k = 0; k < BUS_W; k++)
            if (idx * BUS_W + k < WORD_W) beat_of[k] = w[idx * BUS_W + k];
    endfunction

    log_afpm_core #(.EXP_W(EXP_W), .MAN_W(MAN_W), .COMP(COMP)) u_core (
        .a(a_q), .b(b_q), .mode(mode_q), .res(core_res), .flags(core_flags)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.flags     = flags_q;

    always_comb begin
        state_d     = state_q;
        cnt_in_d    = cnt_in_q;
        cnt_out_d   = cnt_out_q;
        a_d         = a_q;
        b_d         = b_q;
        mode_d      = mode_q;
        res_d       = res_q;
        flags_d     = flags_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        unique case (state_q)
            LOAD: if (bus.in_valid) begin
                // bits of the beat that fall above WORD_W are simply never stored
                for (int k = 0; k < WORD_W; k++)
                    if (k / BUS_W == int'(cnt_in_q)) begin
                        a_d[k] = bus.a_in[k % BUS_W];
                        b_d[k] = bus.b_in[k % BUS_W];
                    end
                if (cnt_in_q == '0) mode_d = bus.mode;
                if (cnt_in_q == CNT_W'(BEATS - 1)) begin
                    cnt_in_d   = '0;
                    in_ready_d = 1'b0;
                    state_d    = COMPUTE;
                end else begin
                    cnt_in_d = cnt_in_q + 1'b1;
                end
            end
            COMPUTE: begin
                res_d       = core_res;
                flags_d     = core_flags;
                cnt_out_d   = '0;
                out_valid_d = 1'b1;
                out_data_d  = beat_of(core_res, 0);
                out_last_d  = (BEATS == 1);
                state_d     = SEND;
            end
            SEND: if (bus.out_ready) begin
                if (cnt_out_q == CNT_W'(BEATS - 1)) begin
                    cnt_out_d   = '0;
                    out_valid_d = 1'b0;
                    out_data_d  = '0;
                    out_last_d  = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = LOAD;
                end else begin
                    cnt_out_d  = cnt_out_q + 1'b1;
                    out_data_d = beat_of(res_q, int'(cnt_out_q) + 1);
                    out_last_d = (int'(cnt_out_q) + 1 == BEATS - 1);
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD;
            cnt_in_q    <= '0;
            cnt_out_q   <= '0;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= 1'b0;
            res_q       <= '0;
            flags_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_in_q    <= cnt_in_d;
            cnt_out_q   <= cnt_out_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mode_q      <= mode_d;
            res_q       <= res_d;
            flags_q     <= flags_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end
endmodule

// File: tb/tb_log_afpm_serial.sv
// Bench for log_afpm_serial: directed table, reset/stall corner cases,
// randomized operands against an arithmetic reference, and an FP32 instance.
module tb_log_afpm_serial;
    localparam int BEATS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    log_afpm_serial_if #(.BUS_W(8)) bus ();
    log_afpm_serial_if #(.BUS_W(8)) bus32 ();

    log_afpm_serial #(.EXP_W(5), .MAN_W(10), .BUS_W(8), .COMP(58)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    log_afpm_serial #(.EXP_W(8), .MAN_W(23), .BUS_W(8), .COMP(58)) dut32 (
        .clk(clk), .rst(rst), .bus(bus32)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        m;
        logic [15:0] res;
        logic [3:0]  fl;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference built from the field-level rules: log-sum with plain integers.
    function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b, input logic m);
        int ea, eb, ma, mb, s;
        logic sg;
        bit an, bn, ai, bi, az, bz;
        ea = int'(a[14:10]); eb = int'(b[14:10]);
        ma = int'(a[9:0]);   mb = int'(b[9:0]);
        sg = a[15] ^ b[15];
        s  = (ea * 1024 + ma) + (eb * 1024 + mb) + (m ? 58 : 0) - 15 * 1024;
        an = (ea == 31) && (ma != 0); bn = (eb == 31) && (mb != 0);
        ai = (ea == 31) && (ma == 0); bi = (eb == 31) && (mb == 0);
        az = (ea == 0);               bz = (eb == 0);
        if (an || bn || (ai && bz) || (bi && az)) return {16'h7E00, 4'b1000};
        if (az || bz)                             return {sg, 15'h0000, 4'b0001};
        if (ai || bi)                             return {sg, 15'h7C00, 4'b0000};
        if (s >= 31 * 1024)                       return {sg, 15'h7C00, 4'b0100};
        if (s < 1024)                             return {sg, 15'h0000, 4'b0011};
        return {sg, s[14:0], 4'b0000};
    endfunction

    task automatic send_op(input logic [15:0] a, input logic [15:0] b, input logic m, input bit gaps);
        int i = 0;
        int guard = 0;
        while (i < BEATS && guard < 200) begin
            @(negedge clk);
            guard++;
            if (gaps && $urandom_range(0, 1) == 1) begin
                bus.in_valid = 1'b0;
                bus.a_in = 8'($urandom);
                bus.b_in = 8'($urandom);
                bus.mode = 1'($urandom);
            end else begin
                bus.in_valid = 1'b1;
                bus.a_in = a[i*8 +: 8];
                bus.b_in = b[i*8 +: 8];
                bus.mode = (i == 0) ? m : ~m;
                if (bus.in_ready) i++;
            end
        end
        if (i < BEATS) check("send_timeout", 32'(i), 32'(BEATS));
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic recv(input bit toggle, output logic [15:0] res, output logic [3:0] fl,
                        output int first_wait);
        int j = 0;
        int guard = 0;
        bit stalled = 0;
        logic [7:0] held = '0;
        logic [3:0] fl0 = '0;
        first_wait = 0;
        res = '0;
        while (j < BEATS && guard < 100) begin
            @(negedge clk);
            guard++;
            // junk offered outside LOAD must be ignored
            bus.in_valid = 1'b1;
            bus.a_in = 8'($urandom);
            bus.b_in = 8'($urandom);
            if (stalled) begin
                check("hold_data", 32'(bus.out_data), 32'(held));
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                stalled = 0;
            end
            bus.out_ready = toggle ? ~bus.out_ready : 1'b1;
            if (bus.out_valid) begin
                if (first_wait == 0) first_wait = guard;
                check("no_overlap", 32'(bus.in_ready), 32'd0);
                if (j == 0) fl0 = bus.flags;
                else check("flags_stable", 32'(bus.flags), 32'(fl0));
                if (bus.out_ready) begin
                    check("out_last", 32'(bus.out_last), 32'(j == BEATS - 1));
                    res[j*8 +: 8] = bus.out_data;
                    j++;
                end else begin
                    stalled = 1;
                    held = bus.out_data;
                end
            end
        end
        if (j < BEATS) check("recv_timeout", 32'(j), 32'(BEATS));
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        check("valid_drop", 32'(bus.out_valid), 32'd0);
        check("ready_back", 32'(bus.in_ready), 32'd1);
        fl = fl0;
    endtask

    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic m, input bit gaps, input bit toggle,
                          input logic [15:0] er, input logic [3:0] ef);
        logic [15:0] r;
        logic [3:0] f;
        int fw;
        send_op(a, b, m, gaps);
        check({name, "_lat_pre"}, 32'(bus.out_valid), 32'd0);
        recv(toggle, r, f, fw);
        if (!toggle) check({name, "_lat"}, 32'(fw), 32'd1);
        check({name, "_res"}, 32'(r), 32'(er));
        check({name, "_flags"}, 32'(f), 32'(ef));
    endtask

    vec_t tbl[6];
    logic [15:0] specials[6];

    initial begin
        logic [19:0] exp_v;
        logic [15:0] ra, rb;
        logic rm;
        logic [31:0] a32, r32;
        int j32;

        bus.in_valid = 1'b0; bus.a_in = '0; bus.b_in = '0; bus.mode = 1'b0; bus.out_ready = 1'b1;
        bus32.in_valid = 1'b0; bus32.a_in = '0; bus32.b_in = '0; bus32.mode = 1'b0; bus32.out_ready = 1'b1;

        tbl[0] = '{16'h3E00, 16'h4200, 1'b0, 16'h4400, 4'b0000};
        tbl[1] = '{16'h3E00, 16'h4200, 1'b1, 16'h443A, 4'b0000};
        tbl[2] = '{16'h7C00, 16'h0000, 1'b0, 16'h7E00, 4'b1000};
        tbl[3] = '{16'h7800, 16'h7800, 1'b0, 16'h7C00, 4'b0100};
        tbl[4] = '{16'h0400, 16'h0400, 1'b0, 16'h0000, 4'b0011};
        tbl[5] = '{16'hBC00, 16'h3C00, 1'b0, 16'hBC00, 4'b0000};
        specials = '{16'h0000, 16'h7C00, 16'h7E01, 16'h8000, 16'h3C00, 16'h0400};

        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_flags", 32'(bus.flags), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].m, 0, 0, tbl[i].res, tbl[i].fl);
        for (int i = 0; i < 6; i++) run_op($sformatf("vecst%0d", i), tbl[i].a, tbl[i].b, tbl[i].m, 1, 1, tbl[i].res, tbl[i].fl);

        // reset after one accepted input beat: partial operand must vanish
        @(negedge clk);
        bus.in_valid = 1'b1; bus.a_in = 8'hFF; bus.b_in = 8'hFF; bus.mode = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        run_op("after_rst", 16'h3C00, 16'h3C00, 1'b0, 0, 0, 16'h3C00, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no_stale", 32'(bus.out_valid), 32'd0);
        end

        // reset while a result is pending: unsent beats are dropped
        send_op(16'h3E00, 16'h4200, 1'b0, 0);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("pending_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_send_valid", 32'(bus.out_valid), 32'd0);
        check("rst_send_data", 32'(bus.out_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("rst_send_idle", 32'(bus.out_valid), 32'd0);
        run_op("after_rst2", 16'h4000, 16'h4000, 1'b0, 0, 0, 16'h4400, 4'b0000);

        for (int n = 0; n < 40; n++) begin
            ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : 16'($urandom);
            rm = 1'($urandom);
            exp_v = model(ra, rb, rm);
            run_op($sformatf("rnd%0d", n), ra, rb, rm, 1'($urandom), 1'($urandom), exp_v[19:4], exp_v[3:0]);
        end

        // FP32 instance: 1.0 * 1.0 over four beats
        a32 = 32'h3F80_0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("fp32_in_ready", 32'(bus32.in_ready), 32'd1);
            bus32.in_valid = 1'b1;
            bus32.a_in = a32[i*8 +: 8];
            bus32.b_in = a32[i*8 +: 8];
        end
        @(negedge clk);
        bus32.in_valid = 1'b0;
        r32 = '0;
        j32 = 0;
        for (int g = 0; g < 20 && j32 < 4; g++) begin
            @(negedge clk);
            if (bus32.out_valid) begin
                check("fp32_last", 32'(bus32.out_last), 32'(j32 == 3));
                r32[j32*8 +: 8] = bus32.out_data;
                j32++;
            end
        end
        check("fp32_beats", 32'(j32), 32'd4);
        check("fp32_res", r32, 32'h3F80_0000);
        check("fp32_flags", 32'(bus32.flags), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
